// File: rtl/line_buf_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// line_buf_ctrl_pkg
//
// Shared constants and types for the ping-pong line-buffer sequencer.
//   - Default geometry of the 256x16 frame-buffer RAM and the line length.
//   - BANK_BITS: the RAM address MSB(s) that select the bank.
//   - line_tag_t: the start/end-of-line tag that travels with every pixel.
//     An output-buffer entry is laid out as {sol, eol, data}, i.e.
//     {line_tag_t, data}.
// -----------------------------------------------------------------------------
package line_buf_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_LINE_LEN   = 128;

    localparam int BANK_BITS  = 1;
    localparam int OBUF_DEPTH = 2;

    typedef struct packed {
        logic sol;
        logic eol;
    } line_tag_t;

    localparam int TAG_BITS = $bits(line_tag_t);

    // Tag for the word at position 'first'/'last' within its line.
    function automatic line_tag_t make_tag(input logic first, input logic last);
        line_tag_t t;
        t.sol = first;
        t.eol = last;
        return t;
    endfunction

endpackage

// File: rtl/lbc_out_buf.sv
// -----------------------------------------------------------------------------
// lbc_out_buf
//
// Two-entry output FIFO that absorbs the RAM's one-cycle read latency so the
// read stream can run at one word per cycle under valid/ready flow control.
// Each entry is {sol, eol, data}.
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset (empties the FIFO)
//   push       in   write push_data/push_tag this cycle
//   push_data  in   RAM word captured from the read port
//   push_tag   in   start/end-of-line tag for that word
//   pop        in   consumer took the head entry this cycle
//   occupancy  out  number of valid entries, 0..2
//   head_data  out  data of the oldest entry
//   head_tag   out  tag of the oldest entry
// -----------------------------------------------------------------------------
module lbc_out_buf
    import line_buf_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  line_tag_t             push_tag,
    input  logic                  pop,
    output logic [1:0]            occupancy,
    output logic [DATA_WIDTH-1:0] head_data,
    output line_tag_t             head_tag
);

    typedef struct packed {
        line_tag_t             tag;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t mem [OBUF_DEPTH];
    logic   wr_ptr;
    logic   rd_ptr;
    logic   do_push;
    logic   do_pop;

    // Guards keep the pointers coherent even if a caller misbehaves; the top
    // never pushes into a full buffer unless it pops in the same cycle.
    assign do_pop  = pop && (occupancy != 2'd0);
    assign do_push = push && ((occupancy != 2'd2) || do_pop);

    // NOTE: storage carries no reset; occupancy alone decides what is valid,
    // so clearing the data words would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= '{tag: push_tag, data: push_data};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   occupancy <= occupancy + 2'd1;
                2'b01:   occupancy <= occupancy - 2'd1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    assign head_data = mem[rd_ptr].data;
    assign head_tag  = mem[rd_ptr].tag;

endmodule

// File: rtl/line_buf_ctrl.sv
// -----------------------------------------------------------------------------
// line_buf_ctrl
//
// Ping-pong line-buffer sequencer for a pseudo-dual-port frame-buffer RAM.
// The RAM is split into two banks of LINE_LEN words (bank = address MSB).
// A producer fills one bank through a valid/ready write stream while the
// consumer drains the other bank through a valid/ready read stream; banks
// swap automatically when a line completes on either side. A 2-entry output
// buffer hides the RAM's registered read latency.
//
// Optional build: define LINE_BUF_CTRL_STATUS_EN to add
//   fill_level  out 2  number of full banks
//   overflow    out 1  sticky: wr_valid seen while wr_ready low (cleared by rst)
//
// Ports:
//   clk           in   single clock for all logic and both RAM ports
//   rst           in   synchronous, active-high reset
//   wr_valid      in   producer word valid
//   wr_data       in   producer word
//   wr_ready      out  controller can accept a word
//   rd_valid      out  output word valid
//   rd_data       out  output word
//   rd_sol        out  rd_data is word 0 of a line
//   rd_eol        out  rd_data is word LINE_LEN-1 of a line
//   rd_ready      in   consumer accepts the word
//   ram_din       out  RAM write data
//   ram_write_en  out  RAM write strobe
//   ram_waddr     out  RAM write address
//   ram_raddr     out  RAM read address
//   ram_dout      in   RAM registered read data, valid 1 cycle after ram_raddr
// -----------------------------------------------------------------------------
module line_buf_ctrl
    import line_buf_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LINE_LEN   = DEF_LINE_LEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_sol,
    output logic                  rd_eol,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_write_en,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_dout
`ifdef LINE_BUF_CTRL_STATUS_EN
    ,
    output logic [1:0]            fill_level,
    output logic                  overflow
`endif
);

    // A line must fit in one bank (half the RAM) and hold at least one word.
    if (ADDR_WIDTH < 2 || LINE_LEN < 1 || LINE_LEN > (1 << (ADDR_WIDTH - BANK_BITS))) begin : g_bad_params
        $error("line_buf_ctrl: LINE_LEN must be in 1..2**(ADDR_WIDTH-1)");
    end

    localparam int CNT_W = ADDR_WIDTH - BANK_BITS;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_LEN - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]       bank_full;
    logic             wr_bank;
    logic             rd_bank;
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] rd_cnt;
    logic             inflight;      // a RAM read was issued last cycle
    line_tag_t        inflight_tag;  // tag travelling with that read

    // -------------------------------------------------------------------------
    // Handshake / control terms
    // -------------------------------------------------------------------------
    logic             wr_accept;
    logic             wr_last;
    logic             rd_issue;
    logic             rd_last;
    logic             pop;
    logic [2:0]       pending;
    logic [1:0]       bank_full_next;

    logic [1:0]            occupancy;
    logic [DATA_WIDTH-1:0] head_data;
    line_tag_t             head_tag;

    assign wr_ready  = !rst && !bank_full[wr_bank];
    assign wr_accept = wr_valid && wr_ready;
    assign wr_last   = wr_accept && (wr_cnt == LAST_IDX);

    assign rd_valid  = !rst && (occupancy != 2'd0);
    assign pop       = rd_valid && rd_ready;

    // Entries that will be buffered after this edge, before counting a new
    // issue. Issuing only while this is below 2 guarantees the returning word
    // always has a free slot next cycle.
    assign pending   = {1'b0, occupancy} + {2'b0, inflight} - {2'b0, pop};
    assign rd_issue  = !rst && bank_full[rd_bank] && (pending < 3'd2);
    assign rd_last   = rd_issue && (rd_cnt == LAST_IDX);

    // The writer only ever sets the bank it owns and the reader only ever
    // clears the bank it owns; the two are always different when both fire,
    // so both updates apply independently.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        bank_full_next = bank_full;
        if (wr_last) bank_full_next[wr_bank] = 1'b1;
        if (rd_last) bank_full_next[rd_bank] = 1'b0;
    end

    // -------------------------------------------------------------------------
    // Bank and pointer registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_full    <= 2'b00;
            wr_bank      <= 1'b0;
            rd_bank      <= 1'b0;
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            inflight     <= 1'b0;
            inflight_tag <= '0;
        end else begin
            bank_full <= bank_full_next;

            if (wr_accept) begin
                if (wr_last) begin
                    wr_cnt  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_cnt  <= wr_cnt + 1'b1;
                end
            end

            if (rd_issue) begin
                if (rd_last) begin
                    rd_cnt  <= '0;
                    rd_bank <= ~rd_bank;
                end else begin
                    rd_cnt  <= rd_cnt + 1'b1;
                end
            end

            // Dropping inflight on reset discards any RAM word still in flight.
            inflight     <= rd_issue;
            inflight_tag <= make_tag(rd_cnt == '0, rd_cnt == LAST_IDX);
        end
    end

    // -------------------------------------------------------------------------
    // RAM port drive
    // -------------------------------------------------------------------------
    assign ram_write_en = wr_accept;
    assign ram_din      = wr_data;
    assign ram_waddr    = rst ? '0 : {wr_bank, wr_cnt};
    assign ram_raddr    = rst ? '0 : {rd_bank, rd_cnt};

    // -------------------------------------------------------------------------
    // Output buffer: RAM data returns one cycle after issue
    // -------------------------------------------------------------------------
    lbc_out_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (ram_dout),
        .push_tag  (inflight_tag),
        .pop       (pop),
        .occupancy (occupancy),
        .head_data (head_data),
        .head_tag  (head_tag)
    );

    // Head fields are masked whenever nothing is valid so idle and reset
    // cycles present zeros rather than stale buffer contents.
    assign rd_data = rd_valid ? head_data : '0;
    assign rd_sol  = rd_valid && head_tag.sol;
    assign rd_eol  = rd_valid && head_tag.eol;

    // -------------------------------------------------------------------------
    // Optional status outputs
    // -------------------------------------------------------------------------
`ifdef LINE_BUF_CTRL_STATUS_EN
    assign fill_level = {1'b0, bank_full[0]} + {1'b0, bank_full[1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (wr_valid && !wr_ready) begin
            overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_line_buf_ctrl.sv
// -----------------------------------------------------------------------------
// tb_line_buf_ctrl
//
// Self-checking bench for line_buf_ctrl with a behavioural 256x16 RAM.
// Expected {sol, eol, data} entries are pushed when a write is accepted and
// compared when the consumer takes a word. Inputs change on the falling edge
// and outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_line_buf_ctrl;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int LL = 128;

    logic          clk;
    logic          rst;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_sol;
    logic          rd_eol;
    logic          rd_ready;
    logic [DW-1:0] ram_din;
    logic          ram_write_en;
    logic [AW-1:0] ram_waddr;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_dout;
`ifdef LINE_BUF_CTRL_STATUS_EN
    logic [1:0]    fill_level;
    logic          overflow;
`endif

    line_buf_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LINE_LEN   (LL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_sol       (rd_sol),
        .rd_eol       (rd_eol),
        .rd_ready     (rd_ready),
        .ram_din      (ram_din),
        .ram_write_en (ram_write_en),
        .ram_waddr    (ram_waddr),
        .ram_raddr    (ram_raddr),
        .ram_dout     (ram_dout)
`ifdef LINE_BUF_CTRL_STATUS_EN
        ,
        .fill_level   (fill_level),
        .overflow     (overflow)
`endif
    );

    // Behavioural pseudo-dual-port RAM with a registered read port.
    logic [DW-1:0] ram [2**AW];
    always @(posedge clk) begin
        if (ram_write_en) ram[ram_waddr] <= ram_din;
        ram_dout <= ram[ram_raddr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Scoreboard and reference model of the write-side position.
    logic [DW+1:0] sb [$];
    int            m_idx  = 0;
    logic          m_bank = 1'b0;

    // Per-cycle sample taken by drive().
    int            smp_cyc;
    logic          acc;
    logic          popd;
    logic [DW+1:0] got;
    logic          got_wr_ready;
    logic          got_rd_valid;
    logic          got_we;
    logic [AW-1:0] got_waddr;
    logic [AW-1:0] got_raddr;
    logic [DW-1:0] got_din;
    logic [AW-1:0] exp_waddr;

    // Apply inputs for one cycle, sample outputs, update the model, advance.
    task automatic drive(input logic r, input logic wv, input logic [DW-1:0] wd, input logic rr);
        rst      = r;
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        #1;
        smp_cyc      = cyc;
        acc          = wr_valid && wr_ready;
        popd         = rd_valid && rd_ready;
        got          = {rd_sol, rd_eol, rd_data};
        got_wr_ready = wr_ready;
        got_rd_valid = rd_valid;
        got_we       = ram_write_en;
        got_waddr    = ram_waddr;
        got_raddr    = ram_raddr;
        got_din      = ram_din;
        if (r) begin
            sb.delete();
            m_idx  = 0;
            m_bank = 1'b0;
        end else if (acc) begin
            exp_waddr = {m_bank, 7'(m_idx)};
            sb.push_back({(m_idx == 0), (m_idx == LL - 1), wd});
            m_idx = m_idx + 1;
            if (m_idx == LL) begin
                m_idx  = 0;
                m_bank = ~m_bank;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic sb_pop(output logic [DW+1:0] e, output logic ok);
        ok = (sb.size() != 0);
        e  = ok ? sb.pop_front() : '0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        logic [DW+1:0] zero18;
        zero18 = '0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 16'hBEEF, 1'b1);
            checks++;
            if (got_wr_ready !== 1'b0 || got_rd_valid !== 1'b0 || got_we !== 1'b0) begin
                failures++;
                $display("FAIL reset_ctrl: wr_ready=%b rd_valid=%b we=%b expected 0 0 0", got_wr_ready, got_rd_valid, got_we);
            end
            checks++;
            if (got !== zero18 || got_waddr !== 8'h00 || got_raddr !== 8'h00) begin
                failures++;
                $display("FAIL reset_data: sol/eol/data=%h waddr=%h raddr=%h expected all 0", got, got_waddr, got_raddr);
            end
        end
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        checks++;
        if (got_wr_ready !== 1'b1 || got_rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: wr_ready=%b rd_valid=%b expected 1 0", got_wr_ready, got_rd_valid);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_one_line();
        int            n_acc = 0, n_pop = 0, last_acc = -1, first_v = -1;
        logic [DW+1:0] e;
        logic          ok;
        for (int i = 0; i < LL + 300 && n_pop < LL; i++) begin
            drive(1'b0, (n_acc < LL), 16'(n_acc), 1'b1);
            if (got_rd_valid && first_v < 0) first_v = smp_cyc;
            if (acc) begin
                checks++;
                if (got_waddr !== exp_waddr || got_din !== 16'(n_acc) || got_we !== 1'b1) begin
                    failures++;
                    $display("FAIL one_line_ramwr: waddr=%h din=%h we=%b expected %h %h 1", got_waddr, got_din, got_we, exp_waddr, 16'(n_acc));
                end
                n_acc++;
                if (n_acc == LL) last_acc = smp_cyc;
            end
            if (popd) begin
                n_pop++;
                sb_pop(e, ok);
                checks++;
                if (!ok || got !== e) begin
                    failures++;
                    $display("FAIL one_line_data: got %h expected %h (queued=%b)", got, e, ok);
                end
            end
        end
        checks++;
        if (first_v !== last_acc + 3) begin
            failures++;
            $display("FAIL one_line_latency: first rd_valid cycle %0d expected %0d", first_v, last_acc + 3);
        end
        checks++;
        if (n_pop !== LL || sb.size() !== 0) begin
            failures++;
            $display("FAIL one_line_count: popped %0d left %0d expected %0d 0", n_pop, sb.size(), LL);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_backpressure();
        int            n_acc = 0, acc256 = -1, first_stall = -1;
        int            n_pop = 0, r0 = -1, rise = -1;
        logic [DW+1:0] e;
        logic          ok;
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 1'b1, 16'h2000 + 16'(n_acc), 1'b0);
            if (acc) begin
                n_acc++;
                if (n_acc == 2 * LL) acc256 = smp_cyc;
            end else if (first_stall < 0) begin
                first_stall = smp_cyc;
            end
        end
        checks++;
        if (n_acc !== 2 * LL || got_wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_fill: accepted %0d wr_ready=%b expected %0d 0", n_acc, got_wr_ready, 2 * LL);
        end
        checks++;
        if (first_stall !== acc256 + 1) begin
            failures++;
            $display("FAIL bp_stall_cycle: first stall %0d expected %0d", first_stall, acc256 + 1);
        end
        for (int i = 0; i < 600 && n_pop < 2 * LL; i++) begin
            drive(1'b0, 1'b0, 16'h0, 1'b1);
            if (r0 < 0) r0 = smp_cyc;
            if (got_wr_ready && rise < 0) rise = smp_cyc;
            if (popd) begin
                n_pop++;
                sb_pop(e, ok);
                checks++;
                if (!ok || got !== e) begin
                    failures++;
                    $display("FAIL bp_data: got %h expected %h (queued=%b)", got, e, ok);
                end
            end
        end
        // Two words were already buffered; word 2 issues on the first ready
        // cycle, so word 127 issues 125 cycles later and wr_ready follows.
        checks++;
        if (rise !== r0 + 126) begin
            failures++;
            $display("FAIL bp_ready_rise: wr_ready rose at %0d expected %0d", rise, r0 + 126);
        end
        checks++;
        if (n_pop !== 2 * LL || sb.size() !== 0) begin
            failures++;
            $display("FAIL bp_count: popped %0d left %0d expected %0d 0", n_pop, sb.size(), 2 * LL);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_streaming();
        int            n_acc = 0, n_pop = 0, first_p = -1, last_p = -1, wr_stall = 0;
        logic [DW+1:0] e;
        logic          ok;
        for (int i = 0; i < 3000 && n_pop < 10 * LL; i++) begin
            drive(1'b0, (n_acc < 10 * LL), 16'h4000 + 16'(n_acc), 1'b1);
            if (wr_valid && !got_wr_ready) wr_stall++;
            if (acc) n_acc++;
            if (popd) begin
                if (first_p < 0) first_p = smp_cyc;
                last_p = smp_cyc;
                n_pop++;
                sb_pop(e, ok);
                checks++;
                if (!ok || got !== e) begin
                    failures++;
                    $display("FAIL stream_data: got %h expected %h (queued=%b)", got, e, ok);
                end
            end
        end
        checks++;
        if (n_pop !== 10 * LL || (last_p - first_p + 1) !== n_pop) begin
            failures++;
            $display("FAIL stream_bubbles: popped %0d over %0d cycles expected %0d over %0d", n_pop, last_p - first_p + 1, 10 * LL, 10 * LL);
        end
        checks++;
        if (wr_stall !== 0) begin
            failures++;
            $display("FAIL stream_wr_stall: writer stalled %0d cycles expected 0", wr_stall);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_random_ready();
        int            n_acc = 0, n_pop = 0;
        logic          prev_stall = 1'b0;
        logic [DW+1:0] prev_got = '0;
        logic [DW+1:0] e;
        logic          ok;
        for (int i = 0; i < 8000 && n_pop < 8 * LL; i++) begin
            drive(1'b0, (n_acc < 8 * LL), 16'($urandom), 1'($urandom_range(0, 1)));
            if (acc) n_acc++;
            if (prev_stall) begin
                checks++;
                if (got_rd_valid !== 1'b1 || got !== prev_got) begin
                    failures++;
                    $display("FAIL rand_hold: valid=%b data %h expected 1 %h", got_rd_valid, got, prev_got);
                end
            end
            prev_stall = got_rd_valid && !rd_ready;
            prev_got   = got;
            if (popd) begin
                n_pop++;
                sb_pop(e, ok);
                checks++;
                if (!ok || got !== e) begin
                    failures++;
                    $display("FAIL rand_data: got %h expected %h (queued=%b)", got, e, ok);
                end
            end
        end
        checks++;
        if (n_pop !== 8 * LL || sb.size() !== 0) begin
            failures++;
            $display("FAIL rand_count: popped %0d left %0d expected %0d 0", n_pop, sb.size(), 8 * LL);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset_mid_line();
        int            n_acc = 0, n_pop = 0;
        logic [DW+1:0] e;
        logic          ok;
        logic [DW+1:0] zero18;
        zero18 = '0;
        for (int i = 0; i < 400 && n_acc < LL + 60; i++) begin
            drive(1'b0, 1'b1, 16'h6000 + 16'(n_acc), 1'b0);
            if (acc) n_acc++;
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 16'hDEAD, 1'b1);
            checks++;
            if (got_wr_ready !== 1'b0 || got_rd_valid !== 1'b0 || got_we !== 1'b0 ||
                got !== zero18 || got_waddr !== 8'h00 || got_raddr !== 8'h00) begin
                failures++;
                $display("FAIL midrst_outputs: rdy=%b vld=%b we=%b data=%h wa=%h ra=%h expected all 0",
                         got_wr_ready, got_rd_valid, got_we, got, got_waddr, got_raddr);
            end
        end
        n_acc = 0;
        for (int i = 0; i < 600 && n_pop < LL; i++) begin
            drive(1'b0, (n_acc < LL), 16'h8000 + 16'(n_acc), 1'b1);
            if (i == 0) begin
                checks++;
                if (got_rd_valid !== 1'b0 || got_waddr !== 8'h00) begin
                    failures++;
                    $display("FAIL midrst_clean: rd_valid=%b waddr=%h expected 0 00", got_rd_valid, got_waddr);
                end
            end
            if (acc) n_acc++;
            if (popd) begin
                n_pop++;
                sb_pop(e, ok);
                checks++;
                if (!ok || got !== e) begin
                    failures++;
                    $display("FAIL midrst_data: got %h expected %h (queued=%b)", got, e, ok);
                end
            end
        end
        checks++;
        if (n_pop !== LL || sb.size() !== 0) begin
            failures++;
            $display("FAIL midrst_count: popped %0d left %0d expected %0d 0", n_pop, sb.size(), LL);
        end
    endtask

`ifdef LINE_BUF_CTRL_STATUS_EN
    // -------------------------------------------------------------------------
    task automatic test_status();
        int n_acc = 0;
        drive(1'b1, 1'b0, 16'h0, 1'b0);
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        checks++;
        if (fill_level !== 2'd0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL status_reset: fill=%0d ovf=%b expected 0 0", fill_level, overflow);
        end
        for (int i = 0; i < 400 && n_acc < 2 * LL; i++) begin
            drive(1'b0, 1'b1, 16'hA000 + 16'(n_acc), 1'b0);
            if (acc) n_acc++;
        end
        checks++;
        if (fill_level !== 2'd2 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL status_full: fill=%0d ovf=%b expected 2 0", fill_level, overflow);
        end
        drive(1'b0, 1'b1, 16'hFFFF, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 16'h0, 1'b0);
        checks++;
        if (fill_level !== 2'd2 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL status_overflow: fill=%0d ovf=%b expected 2 1", fill_level, overflow);
        end
        drive(1'b1, 1'b0, 16'h0, 1'b0);
        checks++;
        if (overflow !== 1'b0 || fill_level !== 2'd0) begin
            failures++;
            $display("FAIL status_clear: fill=%0d ovf=%b expected 0 0", fill_level, overflow);
        end
        drive(1'b0, 1'b0, 16'h0, 1'b0);
    endtask
`endif

    // -------------------------------------------------------------------------
    initial begin
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_one_line();
        test_backpressure();
        test_streaming();
        test_random_ready();
        test_reset_mid_line();
`ifdef LINE_BUF_CTRL_STATUS_EN
        test_status();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_buf_ctrl.md
Name: line_buf_ctrl

Overview:
- Ping-pong line-buffer sequencer for the 256x16 pseudo-dual-port frame-buffer RAM.
- Splits the RAM into two banks of LINE_LEN words and sequences both RAM ports.
- A pixel producer fills one bank through a valid/ready write stream while a display consumer drains the other through a valid/ready read stream.
- Banks swap automatically; the block hides the RAM's 1-cycle read latency behind a small output buffer.

Parameters:
- ADDR_WIDTH, 8: RAM address width. Bank select is the MSB.
- DATA_WIDTH, 16: pixel/RAM word width.
- LINE_LEN, 128: words per line, 1..2^(ADDR_WIDTH-1). Out-of-range values are an elaboration error.

Ports:
- clk  in  1  single clock for all logic and both RAM ports
- rst  in  1  synchronous, active-high reset
- wr_valid  in  1  producer word valid
- wr_data  in  DATA_WIDTH  producer word
- wr_ready  out  1  controller can accept a word
- rd_valid  out  1  output word valid
- rd_data  out  DATA_WIDTH  output word
- rd_sol  out  1  rd_data is word 0 of a line
- rd_eol  out  1  rd_data is word LINE_LEN-1 of a line
- rd_ready  in  1  consumer accepts the word
- ram_din  out  DATA_WIDTH  RAM write data
- ram_write_en  out  1  RAM write strobe
- ram_waddr  out  ADDR_WIDTH  RAM write address
- ram_raddr  out  ADDR_WIDTH  RAM read address
- ram_dout  in  DATA_WIDTH  RAM registered read data, valid 1 cycle after ram_raddr

Behaviour:
- State
  - bank_full[1:0], wr_bank, rd_bank, wr_cnt, rd_cnt.
  - 2-entry output buffer with occupancy 0..2.
  - inflight flag: a read was issued last cycle.
- Reset (synchronous, active-high)
  - All state clears to 0, so both banks are empty and both pointers sit on bank 0.
  - While rst is high: wr_ready=0, rd_valid=0, ram_write_en=0, rd_sol=0, rd_eol=0.
  - rd_data, ram_waddr and ram_raddr are 0.
  - Reset mid-line discards all partial and full lines. Any in-flight RAM data is dropped.
- Write side
  - wr_ready = !rst && !bank_full[wr_bank].
  - A word is accepted when wr_valid && wr_ready. This drives ram_write_en=1, ram_waddr={wr_bank, wr_cnt}, ram_din=wr_data combinationally in the same cycle.
  - On accept, wr_cnt increments.
  - When the accepted word is word LINE_LEN-1: wr_cnt<=0, bank_full[wr_bank]<=1, wr_bank toggles.
- Read issue
  - A read is issued when bank_full[rd_bank] && (occupancy + inflight - pop) < 2. pop = rd_valid && rd_ready.
  - On issue: ram_raddr={rd_bank, rd_cnt}, rd_cnt increments, and an sol/eol tag is pushed alongside.
  - When the last word is issued: rd_cnt<=0, bank_full[rd_bank]<=0, rd_bank toggles. The writer may overwrite that bank from the next cycle; the read data is already captured.
- Read return
  - ram_dout is captured into the buffer on the cycle after issue.
  - rd_valid = occupancy != 0. rd_data/rd_sol/rd_eol come from the head entry and are held stable while rd_valid && !rd_ready.
- Latency and throughput
  - A line completing at edge N gives rd_valid high after edge N+2.
  - Sustained throughput is 1 word/cycle on each side when unobstructed.
- Simultaneous events
  - The writer setting and the reader clearing bank_full in the same cycle always target different banks. Both take effect.
  - Push and pop in the same cycle leave occupancy unchanged.
- Full/empty
  - Both banks full: wr_ready=0.
  - No bank full: no reads issue, and rd_valid falls once the buffer drains.

Optional Feature:
- Macro: LINE_BUF_CTRL_STATUS_EN.
- Defined: adds two outputs.
  - fill_level[1:0] = popcount(bank_full).
  - overflow: sticky bit, set when wr_valid && !wr_ready while rst is low, cleared only by rst.
- Undefined: neither port exists and no related logic is generated. Core behaviour is identical either way.

Decomposition:
- Package/header line_buf_ctrl_pkg holds:
  - default ADDR_WIDTH, DATA_WIDTH, LINE_LEN constants;
  - BANK_BITS = 1;
  - the output-buffer entry layout {sol, eol, data}.
- Sub-module lbc_out_buf: the 2-entry output FIFO with occupancy and the tag fields.
- Bank/pointer logic and RAM-port drive stay in the top module.

Test Plan:
- One line, rd_ready=1: write 0..127 → rd_data reads 0..127 in order; rd_sol on word 0, rd_eol on word 127; first rd_valid 2 cycles after the 128th write.
- Two lines backpressured: rd_ready=0, write 300 words → wr_ready drops after word 256; set rd_ready=1 → 256 words out, wr_ready rises one cycle after the first bank's last read issues.
- Streaming: continuous wr_valid=1 and rd_ready=1 for 10 lines → after initial latency, one rd_valid&&rd_ready per cycle with no bubbles; data matches the written sequence.
- Random rd_ready (50%): 8 lines → no lost or duplicated words; rd_data held stable while stalled.
- Reset at word 60 of line 2 → outputs zero during rst; after release, a new line of 128 words reads back correctly with no stale data.
- Status build: both banks full plus one extra wr_valid → fill_level=2, overflow=1 stays set until rst.
